// File: rtl/hs_stream_width_upsizer.sv
// hs_stream_width_upsizer
// Packs RATIO narrow DATA_WIDTH beats from stream a into one wide word on
// stream b. A beat with a_last closes the word early; b_mask marks the lanes
// that carry data. The b side is fully registered. a_rd depends only on the
// output register state, so an accepted beat never waits on a_vld.

module hs_stream_width_upsizer #(
    parameter int DATA_WIDTH = 8,
    parameter int RATIO      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         a_data,
    input  logic                          a_last,
    input  logic                          a_vld,
    output logic                          a_rd,
    output logic [DATA_WIDTH*RATIO-1:0]   b_data,
    output logic [RATIO-1:0]              b_mask,
    output logic                          b_last,
    output logic                          b_vld,
    input  logic                          b_rd
);

    localparam int WW = DATA_WIDTH * RATIO;
    localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(RATIO - 1);

    logic [CW-1:0] cnt_r;
    logic [WW-1:0] acc_r;

    logic          accept_s;
    logic          at_end_s;
    logic          complete_s;
    logic [CW-1:0] cnt_inc_s;
    logic [WW-1:0] word_s;
    logic [WW-1:0] acc_nxt_s;
    logic [RATIO-1:0] mask_s;

    // Input is ready whenever the output register is empty or draining this cycle.
    assign a_rd = !rst && (!b_vld || b_rd);

    // Beat classification, next lane index and the word/mask a completing beat would produce.
    always_comb begin
        accept_s  = a_vld && a_rd;
        word_s    = {WW{1'b0}};
        acc_nxt_s = acc_r;
        mask_s    = {RATIO{1'b0}};

        if (cnt_r >= LAST_CNT) begin
            at_end_s  = 1'b1;
            cnt_inc_s = {CW{1'b0}};
        end else begin
            at_end_s  = 1'b0;
            cnt_inc_s = cnt_r + CW'(1);
        end

        complete_s = accept_s && (at_end_s || a_last);

        for (int i = 0; i < RATIO; i++) begin
            if (CW'(i) < cnt_r) begin
                word_s[i*DATA_WIDTH +: DATA_WIDTH] = acc_r[i*DATA_WIDTH +: DATA_WIDTH];
                mask_s[i] = 1'b1;
            end else if (CW'(i) == cnt_r) begin
                word_s[i*DATA_WIDTH +: DATA_WIDTH]    = a_data;
                acc_nxt_s[i*DATA_WIDTH +: DATA_WIDTH] = a_data;
                mask_s[i] = 1'b1;
            end else begin
                word_s[i*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
                mask_s[i] = 1'b0;
            end
        end
    end

    // Lane counter and accumulator: fill on plain beats, clear when a word is emitted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
            acc_r <= {WW{1'b0}};
        end else if (complete_s) begin
            cnt_r <= {CW{1'b0}};
            acc_r <= {WW{1'b0}};
        end else if (accept_s) begin
            cnt_r <= cnt_inc_s;
            acc_r <= acc_nxt_s;
        end
    end

    // Output register: load on a completing beat, otherwise empty after a b transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_data <= {WW{1'b0}};
            b_mask <= {RATIO{1'b0}};
            b_last <= 1'b0;
            b_vld  <= 1'b0;
        end else if (complete_s) begin
            b_data <= word_s;
            b_mask <= mask_s;
            b_last <= a_last;
            b_vld  <= 1'b1;
        end else if (b_vld && b_rd) begin
            b_vld  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hs_stream_width_upsizer.sv
// Scoreboard bench for hs_stream_width_upsizer: directed beats push hand-computed
// expected words; monitors pop and compare on every b transfer. A second
// instance with RATIO=3, DATA_WIDTH=2 covers the non-power-of-two wrap.

module tb_hs_stream_width_upsizer;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  mask;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  a_data;
    logic        a_last, a_vld, a_rd;
    logic [31:0] b_data;
    logic [3:0]  b_mask;
    logic        b_last, b_vld, b_rd;

    logic [1:0]  a3_data;
    logic        a3_last, a3_vld, a3_rd;
    logic [5:0]  b3_data;
    logic [2:0]  b3_mask;
    logic        b3_last, b3_vld, b3_rd;

    exp_t q[$];
    exp_t q3[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   stalls = 0;

    always #5 clk = ~clk;

    hs_stream_width_upsizer #(.DATA_WIDTH(8), .RATIO(4)) dut (
        .clk(clk), .rst(rst),
        .a_data(a_data), .a_last(a_last), .a_vld(a_vld), .a_rd(a_rd),
        .b_data(b_data), .b_mask(b_mask), .b_last(b_last), .b_vld(b_vld), .b_rd(b_rd)
    );

    hs_stream_width_upsizer #(.DATA_WIDTH(2), .RATIO(3)) dut3 (
        .clk(clk), .rst(rst),
        .a_data(a3_data), .a_last(a3_last), .a_vld(a3_vld), .a_rd(a3_rd),
        .b_data(b3_data), .b_mask(b3_mask), .b_last(b3_last), .b_vld(b3_vld), .b_rd(b3_rd)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic [3:0] m, input logic l);
        exp_t e;
        e.data = d; e.mask = m; e.last = l;
        q.push_back(e);
    endtask

    task automatic push3(input logic [5:0] d, input logic [2:0] m, input logic l);
        exp_t e;
        e.data = {26'd0, d}; e.mask = {1'b0, m}; e.last = l;
        q3.push_back(e);
    endtask

    // Present one beat on the 8-bit instance and return just after the accepting edge.
    task automatic beat(input logic [7:0] d, input logic l);
        a_data = d; a_last = l; a_vld = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (a_rd) begin
                @(posedge clk);
                #1;
                return;
            end
            stalls++;
        end
        n_vec++; n_err++;
        $display("FAIL beat_timeout: data 0x%0h not accepted within 50 cycles", d);
        a_vld = 1'b0;
    endtask

    // Present one beat on the 2-bit instance and return just after the accepting edge.
    task automatic beat3(input logic [1:0] d, input logic l);
        a3_data = d; a3_last = l; a3_vld = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (a3_rd) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        n_vec++; n_err++;
        $display("FAIL beat3_timeout: data 0x%0h not accepted within 50 cycles", d);
        a3_vld = 1'b0;
    endtask

    task automatic idle();
        a_vld = 1'b0; a_last = 1'b0; a3_vld = 1'b0; a3_last = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Monitor for the 8-bit instance: every b transfer must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (b_vld && b_rd) begin
            if (q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_word: got 0x%0h mask 0x%0h with empty queue", b_data, b_mask);
            end else begin
                e = q.pop_front();
                chk("b_data", {32'd0, b_data}, {32'd0, e.data});
                chk("b_mask", {60'd0, b_mask}, {60'd0, e.mask});
                chk("b_last", {63'd0, b_last}, {63'd0, e.last});
            end
        end
    end

    // Monitor for the RATIO=3 instance.
    always @(negedge clk) begin
        exp_t e;
        if (b3_vld && b3_rd) begin
            if (q3.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_word3: got 0x%0h mask 0x%0h with empty queue", b3_data, b3_mask);
            end else begin
                e = q3.pop_front();
                chk("b3_data", {58'd0, b3_data}, {32'd0, e.data});
                chk("b3_mask", {61'd0, b3_mask}, {60'd0, e.mask});
                chk("b3_last", {63'd0, b3_last}, {63'd0, e.last});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        a_data = 8'h00; a_last = 1'b0; a_vld = 1'b0; b_rd = 1'b1;
        a3_data = 2'b00; a3_last = 1'b0; a3_vld = 1'b0; b3_rd = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_b_vld",  {63'd0, b_vld},  64'd0);
        chk("rst_b_data", {32'd0, b_data}, 64'd0);
        chk("rst_b_mask", {60'd0, b_mask}, 64'd0);
        chk("rst_b_last", {63'd0, b_last}, 64'd0);
        chk("rst_a_rd",   {63'd0, a_rd},   64'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // 1: full word, b_vld for exactly one cycle
        push(32'h44332211, 4'hF, 1'b0);
        beat(8'h11, 1'b0); beat(8'h22, 1'b0); beat(8'h33, 1'b0);
        chk("t1_not_yet", {63'd0, b_vld}, 64'd0);
        beat(8'h44, 1'b0);
        chk("t1_vld_on", {63'd0, b_vld}, 64'd1);
        idle();
        chk("t1_vld_off", {63'd0, b_vld}, 64'd0);

        // 2: early last, next beat in lane 0
        push(32'h0000BBAA, 4'h3, 1'b1);
        beat(8'hAA, 1'b0); beat(8'hBB, 1'b1);
        push(32'h000000CC, 4'h1, 1'b1);
        beat(8'hCC, 1'b1);
        idle();

        // 3: backpressure holds the word and blocks input
        b_rd = 1'b0;
        push(32'h04030201, 4'hF, 1'b0);
        beat(8'h01, 1'b0); beat(8'h02, 1'b0); beat(8'h03, 1'b0); beat(8'h04, 1'b0);
        a_data = 8'h05; a_last = 1'b0; a_vld = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t3_a_rd",   {63'd0, a_rd},   64'd0);
            chk("t3_b_vld",  {63'd0, b_vld},  64'd1);
            chk("t3_b_data", {32'd0, b_data}, 64'h04030201);
        end
        @(posedge clk); #1;
        b_rd = 1'b1;
        beat(8'h05, 1'b0);
        push(32'h00000605, 4'h3, 1'b1);
        beat(8'h06, 1'b1);
        idle();

        // 4: back-to-back words without input stalls
        stalls = 0;
        push(32'h04030201, 4'hF, 1'b0);
        push(32'h08070605, 4'hF, 1'b0);
        for (int i = 1; i <= 8; i++) beat(8'(i), 1'b0);
        idle();
        chk("t4_stalls", 64'(stalls), 64'd0);

        // 5a: async reset discards a partial word
        beat(8'h01, 1'b0); beat(8'h02, 1'b0);
        a_vld = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t5_b_vld", {63'd0, b_vld}, 64'd0);
        chk("t5_a_rd",  {63'd0, a_rd},  64'd0);
        @(posedge clk); #1;
        chk("t5_a_rd_held", {63'd0, a_rd}, 64'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        push(32'h0C0B0A09, 4'hF, 1'b0);
        beat(8'h09, 1'b0); beat(8'h0A, 1'b0); beat(8'h0B, 1'b0); beat(8'h0C, 1'b0);
        idle();

        // 5b: async reset discards a pending output word
        b_rd = 1'b0;
        beat(8'h21, 1'b0); beat(8'h22, 1'b0); beat(8'h23, 1'b0); beat(8'h24, 1'b0);
        a_vld = 1'b0;
        chk("t5b_pending", {63'd0, b_vld}, 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("t5b_b_vld",  {63'd0, b_vld},  64'd0);
        chk("t5b_b_data", {32'd0, b_data}, 64'd0);
        chk("t5b_b_mask", {60'd0, b_mask}, 64'd0);
        @(negedge clk); rst = 1'b0; b_rd = 1'b1;
        @(posedge clk); #1;
        chk("t5b_after", {63'd0, b_vld}, 64'd0);

        // 6: single-beat last, full word with last
        push(32'h0000007E, 4'h1, 1'b1);
        beat(8'h7E, 1'b1);
        push(32'h04030201, 4'hF, 1'b1);
        beat(8'h01, 1'b0); beat(8'h02, 1'b0); beat(8'h03, 1'b0); beat(8'h04, 1'b1);
        idle();

        // 6b: RATIO=3 instance, single-beat last, full word, wrap to lane 0
        push3(6'h03, 3'b001, 1'b1);
        beat3(2'b11, 1'b1);
        push3(6'h39, 3'b111, 1'b0);
        beat3(2'b01, 1'b0); beat3(2'b10, 1'b0); beat3(2'b11, 1'b0);
        push3(6'h02, 3'b001, 1'b1);
        beat3(2'b10, 1'b1);
        idle();

        repeat (3) @(posedge clk);
        #1;
        chk("q_empty",  64'(q.size()),  64'd0);
        chk("q3_empty", 64'(q3.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
